// File: rtl/flash_vram_loader.sv
// Streams a full image from 16-bit flash words into 36-bit ZBT VRAM words.
// Each pixel takes two flash reads (high, then low word) and one arbitrated VRAM write.
module flash_vram_loader #(
   parameter int unsigned NUM_PIXELS = 307200,
   parameter logic [23:0] FLASH_BASE = 24'h000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        flash_req,
   output logic [23:0] flash_addr,
   input  logic        flash_ready,
   input  logic [15:0] flash_data,
   input  logic        vram_grant,
   output logic        vram_we,
   output logic [18:0] vram_addr,
   output logic [35:0] vram_write_data
);

   typedef enum logic [2:0] {IDLE, REQ_HI, REQ_LO, WRITE, DONE} state_t;

   localparam logic [18:0] LAST_IDX = 19'(NUM_PIXELS - 1);

   state_t      state_q, state_d;
   logic [18:0] pixel_idx_q, pixel_idx_d;
   logic [15:0] pixel_hi_q, pixel_hi_d;
   logic        flash_req_q, flash_req_d;
   logic [23:0] flash_addr_q, flash_addr_d;
   logic [18:0] vram_addr_q, vram_addr_d;
   logic [35:0] vram_data_q, vram_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic ack;
   logic last_pixel;

   // An acknowledge only counts while a request is actually outstanding.
   assign ack        = flash_req_q & flash_ready;
   assign last_pixel = (pixel_idx_q == LAST_IDX);

   function automatic logic [23:0] word_addr(input logic [18:0] idx, input logic lo);
      return FLASH_BASE + {4'b0, idx, 1'b0} + {23'b0, lo};
   endfunction

   // NOTE: every flop, data registers included, is reset so outputs are defined the instant reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pixel_idx_q  <= '0;
         pixel_hi_q   <= '0;
         flash_req_q  <= 1'b0;
         flash_addr_q <= '0;
         vram_addr_q  <= '0;
         vram_data_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         pixel_idx_q  <= pixel_idx_d;
         pixel_hi_q   <= pixel_hi_d;
         flash_req_q  <= flash_req_d;
         flash_addr_q <= flash_addr_d;
         vram_addr_q  <= vram_addr_d;
         vram_data_q  <= vram_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start)      state_d = REQ_HI;
         REQ_HI:     if (ack)        state_d = REQ_LO;
         REQ_LO:     if (ack)        state_d = WRITE;
         WRITE:      if (vram_grant) state_d = last_pixel ? DONE : REQ_HI;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      pixel_idx_d  = pixel_idx_q;
      pixel_hi_d   = pixel_hi_q;
      flash_req_d  = flash_req_q;
      flash_addr_d = flash_addr_q;
      vram_addr_d  = vram_addr_q;
      vram_data_d  = vram_data_q;
      busy_d       = busy_q;
      done_d       = done_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pixel_idx_d  = '0;
               done_d       = 1'b0;
               busy_d       = 1'b1;
               flash_req_d  = 1'b1;
               flash_addr_d = FLASH_BASE;
            end
         end
         REQ_HI: begin
            if (ack) begin
               pixel_hi_d   = flash_data;
               flash_addr_d = word_addr(pixel_idx_q, 1'b1);
            end
         end
         REQ_LO: begin
            // Stage the complete VRAM word now so it stays frozen across grant stalls.
            if (ack) begin
               flash_req_d = 1'b0;
               vram_addr_d = pixel_idx_q;
               vram_data_d = {6'b0, pixel_hi_q, flash_data[15:2]};
               if (!last_pixel) flash_addr_d = word_addr(pixel_idx_q + 19'd1, 1'b0);
            end
         end
         WRITE: begin
            if (vram_grant) begin
               if (last_pixel) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  pixel_idx_d = pixel_idx_q + 19'd1;
                  flash_req_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign vram_we         = (state_q == WRITE) & vram_grant;
   assign busy            = busy_q;
   assign done            = done_q;
   assign flash_req       = flash_req_q;
   assign flash_addr      = flash_addr_q;
   assign vram_addr       = vram_addr_q;
   assign vram_write_data = vram_data_q;

endmodule

// File: tb/tb_flash_vram_loader.sv
// Directed bench for flash_vram_loader on a reduced 8-pixel image with flash and VRAM models.
module tb_flash_vram_loader;

   localparam int          NP   = 8;
   localparam logic [23:0] BASE = 24'h000100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, flash_req, vram_we;
   logic [23:0] flash_addr;
   logic        flash_ready = 1'b0;
   logic [15:0] flash_data = 16'h0;
   logic        vram_grant = 1'b0;
   logic [18:0] vram_addr;
   logic [35:0] vram_write_data;

   int checks = 0;
   int errors = 0;

   logic [15:0] flash_mem [2*NP];
   logic [35:0] vram_mem  [NP];
   int          wr_cyc    [NP];
   int          cyc = 0;
   int          wr_count = 0;
   int          seq_err = 0;
   logic [18:0] last_wr_addr = '0;
   logic [23:0] last_ack_addr = '0;

   always #5 clk = ~clk;

   flash_vram_loader #(.NUM_PIXELS(NP), .FLASH_BASE(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .flash_req(flash_req), .flash_addr(flash_addr), .flash_ready(flash_ready),
      .flash_data(flash_data), .vram_grant(vram_grant), .vram_we(vram_we),
      .vram_addr(vram_addr), .vram_write_data(vram_write_data)
   );

   // VRAM model: captures every strobed write and checks linear ordering.
   always @(posedge clk) begin
      cyc++;
      if (vram_we) begin
         if (int'(vram_addr) < NP) begin
            vram_mem[vram_addr] = vram_write_data;
            wr_cyc[vram_addr]   = cyc;
         end
         if (int'(vram_addr) != wr_count) seq_err++;
         last_wr_addr = vram_addr;
         wr_count++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] flash_word(input logic [23:0] a);
      logic [23:0] off;
      off = a - BASE;
      if (int'(off) < 2*NP) return flash_mem[off];
      return 16'h0000;
   endfunction

   function automatic logic [35:0] exp_word(input int p);
      logic [15:0] lo;
      lo = flash_mem[2*p+1];
      return {6'b0, flash_mem[2*p], lo[15:2]};
   endfunction

   function automatic int count_vram_bad();
      int n = 0;
      for (int p = 0; p < NP; p++) if (vram_mem[p] !== exp_word(p)) n++;
      return n;
   endfunction

   task automatic clear_log();
      wr_count      = 0;
      seq_err       = 0;
      last_wr_addr  = '0;
      last_ack_addr = '0;
      for (int p = 0; p < NP; p++) vram_mem[p] = 36'hF_0000_0000;
   endtask

   task automatic fill_flash(input int seed, input bit rnd);
      for (int i = 0; i < 2*NP; i++)
         flash_mem[i] = rnd ? 16'($urandom) : 16'((i + 1) * 16'h1357 ^ seed * 16'h0F0F);
   endtask

   task automatic pulse_start();
      start = 1'b1; flash_ready = 1'b0; vram_grant = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Flash/VRAM responder: mode 0 answers instantly, mode 1 answers randomly (incl. spurious ready).
   task automatic serve(input int mode, input int budget, output int cycles, output bit timeout);
      cycles = 0; timeout = 1'b0;
      while (!done) begin
         if (cycles >= budget) begin timeout = 1'b1; break; end
         if (mode == 0) begin
            flash_ready = flash_req;
            vram_grant  = 1'b1;
         end else begin
            flash_ready = ($urandom_range(0, 2) == 0);
            vram_grant  = ($urandom_range(0, 2) == 0);
         end
         flash_data = flash_ready ? flash_word(flash_addr) : 16'hDEAD;
         if (flash_req && flash_ready) last_ack_addr = flash_addr;
         @(negedge clk);
         cycles++;
      end
      flash_ready = 1'b0;
      vram_grant  = 1'b0;
   endtask

   task automatic advance_to(input logic [23:0] target, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < 200; i++) begin
         flash_ready = 1'b0; vram_grant = 1'b0;
         if (flash_req && flash_addr == target) begin timeout = 1'b0; break; end
         flash_ready = flash_req;
         vram_grant  = 1'b1;
         flash_data  = flash_word(flash_addr);
         @(negedge clk);
      end
      flash_ready = 1'b0; vram_grant = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, flash_req, vram_we} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, flash_req, vram_we});
      end
      checks++;
      if (flash_addr !== 24'h0) begin errors++; $display("FAIL reset_flash_addr got %h want 0", flash_addr); end
      checks++;
      if (vram_addr !== 19'h0) begin errors++; $display("FAIL reset_vram_addr got %h want 0", vram_addr); end
      checks++;
      if (vram_write_data !== 36'h0) begin errors++; $display("FAIL reset_vram_data got %h want 0", vram_write_data); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, flash_req} !== 3'b0) begin
         errors++; $display("FAIL idle_after_reset got %b want 000", {busy, done, flash_req});
      end
   endtask

   task automatic test_single_pixel();
      int n; bit to;
      clear_log();
      fill_flash(1, 1'b0);
      flash_mem[0] = 16'hABCD;
      flash_mem[1] = 16'h1237;
      pulse_start();
      checks++;
      if (flash_req !== 1'b1 || flash_addr !== BASE || busy !== 1'b1) begin
         errors++; $display("FAIL start_edge got req=%b addr=%h busy=%b want 1 %h 1", flash_req, flash_addr, busy, BASE);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %0d want 0", to); end
      checks++;
      if (n !== 3*NP) begin errors++; $display("FAIL single_cycles got %0d want %0d", n, 3*NP); end
      checks++;
      if (vram_mem[0] !== 36'h0_2AF3_448D) begin
         errors++; $display("FAIL pixel0_pack got %h want 02af3448d", vram_mem[0]);
      end
      checks++;
      if (count_vram_bad() !== 0) begin errors++; $display("FAIL single_image bad=%0d want 0", count_vram_bad()); end
      checks++;
      if (wr_count !== NP || seq_err !== 0) begin
         errors++; $display("FAIL single_writes got %0d seq_err=%0d want %0d 0", wr_count, seq_err, NP);
      end
      checks++;
      if (wr_cyc[NP-1] - wr_cyc[0] !== 3*(NP-1)) begin
         errors++; $display("FAIL write_spacing got %0d want %0d", wr_cyc[NP-1] - wr_cyc[0], 3*(NP-1));
      end
      checks++;
      if ({done, busy, flash_req} !== 3'b100) begin
         errors++; $display("FAIL single_done got %b want 100", {done, busy, flash_req});
      end
   endtask

   task automatic test_grant_stall();
      int n; bit to;
      clear_log();
      fill_flash(2, 1'b0);
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         flash_ready = 1'b1;
         flash_data  = flash_word(flash_addr);
         @(negedge clk);
      end
      flash_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vram_grant = 1'b0;
         #1;
         checks++;
         if (vram_we !== 1'b0 || flash_req !== 1'b0 || vram_addr !== 19'd0 || vram_write_data !== exp_word(0)) begin
            errors++;
            $display("FAIL stall_%0d got we=%b req=%b addr=%h data=%h want 0 0 0 %h",
                     i, vram_we, flash_req, vram_addr, vram_write_data, exp_word(0));
         end
         @(negedge clk);
      end
      vram_grant = 1'b1;
      #1;
      checks++;
      if (vram_we !== 1'b1) begin errors++; $display("FAIL stall_release_we got %b want 1", vram_we); end
      @(negedge clk);
      vram_grant = 1'b0;
      checks++;
      if (wr_count !== 1 || flash_req !== 1'b1 || flash_addr !== BASE + 24'd2) begin
         errors++; $display("FAIL stall_after got wr=%0d req=%b addr=%h want 1 1 %h", wr_count, flash_req, flash_addr, BASE + 24'd2);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0 || wr_count !== NP || count_vram_bad() !== 0) begin
         errors++; $display("FAIL stall_image got to=%0d wr=%0d bad=%0d want 0 %0d 0", to, wr_count, count_vram_bad(), NP);
      end
   endtask

   task automatic test_slow_flash();
      int n; bit to;
      clear_log();
      fill_flash(3, 1'b0);
      flash_ready = 1'b1; flash_data = 16'hDEAD;
      repeat (3) @(negedge clk);
      flash_ready = 1'b0;
      checks++;
      if ({flash_req, busy, done} !== 3'b001) begin
         errors++; $display("FAIL spurious_in_done got %b want 001", {flash_req, busy, done});
      end
      pulse_start();
      for (int half = 0; half < 2; half++) begin
         for (int i = 0; i < 7; i++) begin
            flash_ready = 1'b0;
            flash_data  = 16'hDEAD ^ 16'(i);
            checks++;
            if (flash_req !== 1'b1 || flash_addr !== BASE + 24'(half)) begin
               errors++; $display("FAIL slow_hold_%0d_%0d got req=%b addr=%h want 1 %h", half, i, flash_req, flash_addr, BASE + 24'(half));
            end
            @(negedge clk);
         end
         flash_ready = 1'b1;
         flash_data  = flash_mem[half];
         @(negedge clk);
      end
      flash_ready = 1'b1; flash_data = 16'hBEEF; vram_grant = 1'b0;
      repeat (2) @(negedge clk);
      flash_ready = 1'b0;
      checks++;
      if (flash_req !== 1'b0 || vram_write_data !== exp_word(0)) begin
         errors++; $display("FAIL slow_capture got req=%b data=%h want 0 %h", flash_req, vram_write_data, exp_word(0));
      end
      vram_grant = 1'b1;
      @(negedge clk);
      vram_grant = 1'b0;
      checks++;
      if (flash_req !== 1'b1 || flash_addr !== BASE + 24'd2) begin
         errors++; $display("FAIL slow_next_req got req=%b addr=%h want 1 %h", flash_req, flash_addr, BASE + 24'd2);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0 || count_vram_bad() !== 0) begin
         errors++; $display("FAIL slow_image got to=%0d bad=%0d want 0 0", to, count_vram_bad());
      end
   endtask

   task automatic test_back_to_back();
      int n; bit to;
      clear_log();
      fill_flash(4, 1'b0);
      pulse_start();
      advance_to(BASE + 24'd4, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL busy_reach got timeout=%0d want 0", to); end
      start = 1'b1; flash_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done, flash_req} !== 3'b101 || flash_addr !== BASE + 24'd4) begin
         errors++; $display("FAIL start_ignored got flags=%b addr=%h want 101 %h", {busy, done, flash_req}, flash_addr, BASE + 24'd4);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0 || wr_count !== NP || count_vram_bad() !== 0 || done !== 1'b1) begin
         errors++; $display("FAIL busy_complete got to=%0d wr=%0d bad=%0d done=%b want 0 %0d 0 1", to, wr_count, count_vram_bad(), done, NP);
      end
      clear_log();
      fill_flash(5, 1'b0);
      pulse_start();
      checks++;
      if ({busy, done, flash_req} !== 3'b101 || flash_addr !== BASE) begin
         errors++; $display("FAIL restart got flags=%b addr=%h want 101 %h", {busy, done, flash_req}, flash_addr, BASE);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0 || wr_count !== NP || seq_err !== 0 || count_vram_bad() !== 0) begin
         errors++; $display("FAIL restart_image got to=%0d wr=%0d seq=%0d bad=%0d want 0 %0d 0 0", to, wr_count, seq_err, count_vram_bad(), NP);
      end
   endtask

   task automatic test_reset_mid_load();
      int n; bit to;
      clear_log();
      fill_flash(6, 1'b0);
      pulse_start();
      advance_to(BASE + 24'd11, to);
      checks++;
      if (to !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reach_pixel5_lo got to=%0d busy=%b want 0 1", to, busy); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, flash_req, vram_we} !== 4'b0 || flash_addr !== 24'h0 || vram_addr !== 19'h0 || vram_write_data !== 36'h0) begin
         errors++; $display("FAIL async_reset got flags=%b addr=%h va=%h vd=%h want 0 0 0 0",
                            {busy, done, flash_req, vram_we}, flash_addr, vram_addr, vram_write_data);
      end
      @(negedge clk);
      vram_grant = 1'b1;
      #1;
      checks++;
      if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_no_write got %b want 0", vram_we); end
      vram_grant = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      clear_log();
      fill_flash(7, 1'b0);
      pulse_start();
      checks++;
      if (flash_req !== 1'b1 || flash_addr !== BASE) begin
         errors++; $display("FAIL reload_start got req=%b addr=%h want 1 %h", flash_req, flash_addr, BASE);
      end
      serve(0, 200, n, to);
      checks++;
      if (to !== 1'b0 || wr_count !== NP || seq_err !== 0 || count_vram_bad() !== 0) begin
         errors++; $display("FAIL reload_image got to=%0d wr=%0d seq=%0d bad=%0d want 0 %0d 0 0", to, wr_count, seq_err, count_vram_bad(), NP);
      end
   endtask

   task automatic test_random_frame();
      int n; bit to;
      for (int run = 0; run < 2; run++) begin
         clear_log();
         fill_flash(0, 1'b1);
         pulse_start();
         serve(1, 3000, n, to);
         checks++;
         if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %0d want 0", run, to); end
         checks++;
         if (count_vram_bad() !== 0 || wr_count !== NP || seq_err !== 0) begin
            errors++; $display("FAIL rand%0d_image got bad=%0d wr=%0d seq=%0d want 0 %0d 0", run, count_vram_bad(), wr_count, seq_err, NP);
         end
         checks++;
         if (last_wr_addr !== 19'(NP - 1) || last_ack_addr !== BASE + 24'(2*NP - 1)) begin
            errors++; $display("FAIL rand%0d_last got va=%h fa=%h want %h %h", run, last_wr_addr, last_ack_addr, 19'(NP - 1), BASE + 24'(2*NP - 1));
         end
         checks++;
         if ({done, busy} !== 2'b10) begin errors++; $display("FAIL rand%0d_done got %b want 10", run, {done, busy}); end
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_grant_stall();
      test_slow_flash();
      test_back_to_back();
      test_reset_mid_load();
      test_random_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_vram_loader.md
# flash_vram_loader

Copies a full 640x480 image from the external flash into ZBT video RAM. Each 30-bit pixel ({R[9:0],G[9:0],B[9:0]}) is stored as two consecutive 16-bit flash words. The loader packs each pair into one VRAM word at the same linear address (x + y*640) that the display read stage fetches from. It is the stage directly upstream of the VRAM display reader. It writes only when the VRAM arbiter grants the port, typically during blanking.

## Interface
- NUM_PIXELS, 307200, pixels per load (640*480); last written address is NUM_PIXELS-1
- FLASH_BASE, 0, flash word address of pixel 0's high word

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; one clock domain only
- start  in  1  one-cycle pulse; begins a load when idle or done
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered
- done  out  1  high in DONE; held until the next accepted start
- flash_req  out  1  read request; held with flash_addr stable until acknowledged
- flash_addr  out  24  flash word address
- flash_ready  in  1  one-cycle acknowledge; flash_data valid in the same cycle
- flash_data  in  16  flash read word
- vram_grant  in  1  VRAM port available to the writer this cycle
- vram_we  out  1  write strobe = (state==WRITE) & vram_grant (combinational)
- vram_addr  out  19  VRAM word address (linear pixel index)
- vram_write_data  out  36  {6'b0, pixel[29:0]}

## Operation
- States: IDLE, REQ_HI, REQ_LO, WRITE, DONE.
- IDLE/DONE + start: pixel_idx<=0, done<=0, busy<=1, go to REQ_HI.
- start while in REQ_HI, REQ_LO or WRITE is ignored.
- REQ_HI:
  - flash_req=1, flash_addr=FLASH_BASE+2*pixel_idx.
  - On flash_req & flash_ready: pixel[29:14]<=flash_data; go to REQ_LO.
- REQ_LO:
  - flash_req=1, flash_addr=FLASH_BASE+2*pixel_idx+1.
  - On ack: pixel[13:0]<=flash_data[15:2] (bits [1:0] discarded); go to WRITE.
- WRITE:
  - flash_req=0; vram_addr=pixel_idx; vram_write_data={6'b0,pixel}.
  - Stays in WRITE while vram_grant=0.
  - When vram_grant=1, vram_we=1 for that cycle. Then: if pixel_idx==NUM_PIXELS-1, go to DONE (busy<=0, done<=1). Otherwise pixel_idx<=pixel_idx+1 and go to REQ_HI.
- Address arithmetic:
  - pixel_idx is 19 bits. Flash address is computed in 24 bits as FLASH_BASE + {pixel_idx,1'b0} (+1 for the low word); wrap modulo 2^24 is permitted.
  - pixel_idx never exceeds NUM_PIXELS-1; it does not wrap.
- flash_ready while flash_req=0 is ignored.
- vram_grant outside WRITE has no effect.
- Reset (any state, including mid-load) forces IDLE immediately. No partial VRAM write is issued after reset assertion.

## Timing
- Reset values: busy=0, done=0, flash_req=0, flash_addr=0, vram_we=0, vram_addr=0, vram_write_data=0, pixel_idx=0.
- flash_req, flash_addr, vram_addr, vram_write_data, busy and done are registered.
- start sampled at edge N: flash_req=1 with addr FLASH_BASE from edge N onward.
- Minimum 3 cycles per pixel: ack in REQ_HI, ack in REQ_LO, grant in WRITE.
- Full-image minimum is 3*NUM_PIXELS cycles plus 1 start cycle.
- flash_addr changes only on the edge that consumes an ack. It is never altered while a request is pending.
- vram_addr and vram_write_data are stable throughout WRITE, including grant stalls.
- done rises on the edge after the final granted write. busy falls on the same edge.

## Test plan
- **Reset mid-load.** Assert reset while in REQ_LO at pixel 5 -> all outputs go to 0 asynchronously. A new start reloads from pixel 0 at flash_addr FLASH_BASE.
- **Single pixel, NUM_PIXELS=4, ready always high, grant always high.** Flash words 16'hABCD then 16'h1237 -> vram_addr=0, vram_write_data=36'h0_2AF3_448D ({16'hABCD,14'h048D}). Writes occur every 3 cycles at addresses 0..3. done=1 after the 4th write.
- **Grant stall.** Hold vram_grant=0 for 10 cycles in WRITE -> vram_we=0, outputs stable, flash_req=0. The write happens in the first cycle with grant=1.
- **Slow flash.** flash_ready arrives 7 cycles after the request -> flash_addr is held constant for all 7 cycles. Data is captured only in the ack cycle; a spurious flash_ready while flash_req=0 is ignored.
- **Start while busy, then restart.** A start pulse in REQ_HI mid-load is ignored and the load completes normally. A start pulse in DONE clears done, sets busy, and restarts at pixel 0.
- **Full frame, NUM_PIXELS=307200, random ready/grant delays.** Last write goes to vram_addr=307199 with the last flash address FLASH_BASE+614399. The bench verifies the VRAM model contents against the source image.
